// File: rtl/stream_downsizer_if.sv
// stream_downsizer_if
//   Bundles the wide input stream and the narrow output stream of the
//   downsizer.
//   slave  : the downsizer's view. It consumes the s_* word stream and
//            produces the m_* beat stream.
//   master : the environment's view. It drives the s_* word stream and
//            m_ready_i, and observes s_ready_o and the m_* beat stream.
//   s_data_i  DW_OUT*SCALE  wide input word
//   s_lanes_i LW            valid lanes in the word (0 or >SCALE means SCALE)
//   s_last_i  1             word ends a packet
//   s_valid_i 1             input word valid
//   s_ready_o 1             downsizer accepts the word this cycle
//   m_data_o  DW_OUT        current output lane
//   m_last_o  1             final beat of a packet-ending word
//   m_valid_o 1             output beat valid
//   m_ready_i 1             downstream accepts the beat
interface stream_downsizer_if #(
   parameter int DW_OUT = 8,
   parameter int SCALE  = 4
);
   localparam int LW = $clog2(SCALE) + 1;

   logic [DW_OUT*SCALE-1:0] s_data_i;
   logic [LW-1:0]           s_lanes_i;
   logic                    s_last_i;
   logic                    s_valid_i;
   logic                    s_ready_o;
   logic [DW_OUT-1:0]       m_data_o;
   logic                    m_last_o;
   logic                    m_valid_o;
   logic                    m_ready_i;

   modport slave (
      input  s_data_i, s_lanes_i, s_last_i, s_valid_i, m_ready_i,
      output s_ready_o, m_data_o, m_last_o, m_valid_o
   );

   modport master (
      output s_data_i, s_lanes_i, s_last_i, s_valid_i, m_ready_i,
      input  s_ready_o, m_data_o, m_last_o, m_valid_o
   );
endinterface

// File: rtl/stream_downsizer.sv
// stream_downsizer
//   Splits each wide stream word into up to SCALE narrow beats. Lane 0 is
//   emitted first, or the top lane when BIG_ENDIAN=1. A word may carry fewer
//   valid lanes (s_lanes_i). The packet-end flag appears on the final beat of
//   the word only.
//   clk  : rising-edge clock
//   rst  : synchronous reset, active-high
//   bus  : stream_downsizer_if.slave (s_* word input, m_* beat output)
module stream_downsizer #(
   parameter int DW_OUT     = 8,
   parameter int SCALE      = 4,
   parameter int BIG_ENDIAN = 0
) (
   input  logic                clk,
   input  logic                rst,
   stream_downsizer_if.slave   bus
);
   localparam int LW = $clog2(SCALE) + 1;
   localparam int IW = $clog2(SCALE);

   typedef enum logic {ST_EMPTY, ST_FULL} state_t;

   state_t                        state_q, state_d;
   logic [SCALE-1:0][DW_OUT-1:0]  word_q, word_d;
   logic [LW-1:0]                 n_q, n_d;
   logic                          last_q, last_d;
   logic [IW-1:0]                 idx_q, idx_d;
   logic                          rst_r_q;

   logic [LW-1:0]                 lanes_eff;
   logic [IW-1:0]                 sel;
   logic                          last_lane;
   logic                          full;
   logic                          wr, rd;
   logic                          s_ready;

   assign full      = (state_q == ST_FULL);
   assign last_lane = ({1'b0, idx_q} == n_q - LW'(1));

   // Out-of-range or zero lane counts mean a full word.
   always_comb begin
      lanes_eff = bus.s_lanes_i;
      if (bus.s_lanes_i == '0 || bus.s_lanes_i > LW'(SCALE))
         lanes_eff = LW'(SCALE);
   end

   // Partial words in big-endian mode still start from the top lane.
   assign sel = (BIG_ENDIAN != 0) ? (IW'(SCALE - 1) - idx_q) : idx_q;

   // Ready while empty, or when the final lane leaves this cycle so the next
   // word loads on the same edge (no bubble). Held off for one extra cycle
   // after reset.
   assign s_ready = !rst && !rst_r_q && (!full || (bus.m_ready_i && last_lane));

   assign wr = bus.s_valid_i && s_ready;
   assign rd = full && bus.m_ready_i;

   assign bus.s_ready_o = s_ready;
   assign bus.m_valid_o = full;
   assign bus.m_data_o  = full ? word_q[sel] : '0;
   assign bus.m_last_o  = full && last_q && last_lane;

   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      n_d     = n_q;
      last_d  = last_q;
      idx_d   = idx_q;
      if (full) begin
         if (rd) begin
            if (!last_lane) begin
               idx_d = idx_q + IW'(1);
            end else begin
               idx_d = '0;
               if (wr) begin
                  word_d = bus.s_data_i;
                  n_d    = lanes_eff;
                  last_d = bus.s_last_i;
               end else begin
                  state_d = ST_EMPTY;
               end
            end
         end
      end else if (wr) begin
         word_d  = bus.s_data_i;
         n_d     = lanes_eff;
         last_d  = bus.s_last_i;
         idx_d   = '0;
         state_d = ST_FULL;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_EMPTY;
         word_q  <= '0;
         n_q     <= LW'(SCALE);
         last_q  <= 1'b0;
         idx_q   <= '0;
         rst_r_q <= 1'b1;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         n_q     <= n_d;
         last_q  <= last_d;
         idx_q   <= idx_d;
         rst_r_q <= 1'b0;
      end
   end
endmodule
